// File: rtl/bank_pkg.sv
// Shared definitions for the register-bank loader and the register bank:
// bus widths, bank address map and the loader state encoding.
package bank_pkg;

  localparam int AMBA_WORD       = 16;
  localparam int AMBA_ADDR_DEPTH = 20;
  localparam int MAX_SIZE        = 720;

  // Bank address map
  localparam int ADDR_CTRL     = 0;
  localparam int ADDR_WHITE    = 1;
  localparam int ADDR_PSIZE    = 2;
  localparam int ADDR_WSIZE    = 3;
  localparam int ADDR_HDR_LAST = 9;
  localparam int ADDR_PIX0     = 'h0A;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    CALC  = 3'd2,
    PIX   = 3'd3,
    START = 3'd4,
    DONE  = 3'd5
  } loader_state_e;

endpackage

// File: rtl/bank_size_calc.sv
// Registered pixel-count calculator: total = Np*Np + Nw*Nw and a range flag
// raised when either size exceeds MAX. The result settles one clock after
// the sizes change, long before the loader reaches its CALC state.
module bank_size_calc #(
  parameter int W   = 16,
  parameter int AW  = 21,
  parameter int MAX = 720
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  i_np,
  input  logic [W-1:0]  i_nw,
  output logic [AW-1:0] o_total,
  output logic          o_range_err
);

  logic [AW-1:0] w_np_sq;
  logic [AW-1:0] w_nw_sq;
  logic [AW-1:0] r_total;
  logic          r_range_err;

  // Squares are only meaningful for legal sizes, which always fit in AW bits.
  assign w_np_sq = AW'(i_np) * AW'(i_np);
  assign w_nw_sq = AW'(i_nw) * AW'(i_nw);

  // Register the sum and the range check.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst) begin
      r_total     <= '0;
      r_range_err <= 1'b0;
    end else begin
      r_total     <= w_np_sq + w_nw_sq;
      r_range_err <= (i_np > W'(MAX)) || (i_nw > W'(MAX));
    end
  end

  assign o_total     = r_total;
  assign o_range_err = r_range_err;

endmodule

// File: rtl/bank_loader.sv
// Register-bank loader: takes a valid/ready word stream (9 header words then
// Np*Np + Nw*Nw pixels), writes it to bank addresses 0x01 upward and finally
// writes CTRL=1 to launch processing. All outputs are registered.
// Optional feature: define LOADER_CHECKSUM_EN to add the checksum output
// (modulo-2^Amba_Word sum of all header and pixel words written).
module bank_loader
  import bank_pkg::*;
#(
  parameter int Amba_Word       = AMBA_WORD,
  parameter int Amba_Addr_Depth = AMBA_ADDR_DEPTH,
  parameter int Max_Size        = MAX_SIZE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     go,
  input  logic                     s_valid,
  input  logic [Amba_Word-1:0]     s_data,
  output logic                     s_ready,
  output logic                     write_en,
  output logic [Amba_Addr_Depth:0] addr,
  output logic [Amba_Word-1:0]     data_out,
  output logic                     busy,
  output logic                     done,
  output logic                     err
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [Amba_Word-1:0]     checksum
`endif
);

  localparam int AW = Amba_Addr_Depth + 1;
  localparam int CW = 4;

  loader_state_e        r_state,    w_state;
  logic [CW-1:0]        r_hdr_cnt,  w_hdr_cnt;
  logic [AW-1:0]        r_pix_addr, w_pix_addr;
  logic [Amba_Word-1:0] r_np,       w_np;
  logic [Amba_Word-1:0] r_nw,       w_nw;
  logic                 r_s_ready,  w_s_ready;
  logic                 r_write_en, w_write_en;
  logic [AW-1:0]        r_addr,     w_addr;
  logic [Amba_Word-1:0] r_data,     w_data;
  logic                 r_busy,     w_busy;
  logic                 r_done,     w_done;
  logic                 r_err,      w_err;
`ifdef LOADER_CHECKSUM_EN
  logic [Amba_Word-1:0] r_checksum, w_checksum;
`endif

  logic [AW-1:0]        w_total;
  logic                 w_range_err;
  logic                 w_accept;

  bank_size_calc #(
    .W   (Amba_Word),
    .AW  (AW),
    .MAX (Max_Size)
  ) u_size_calc (
    .clk         (clk),
    .rst         (rst),
    .i_np        (r_np),
    .i_nw        (r_nw),
    .o_total     (w_total),
    .o_range_err (w_range_err)
  );

  // s_ready is a registered decode of the state, so acceptance is simply this.
  assign w_accept = r_s_ready & s_valid;

  // Next-state and next-output decode.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    w_state    = r_state;
    w_hdr_cnt  = r_hdr_cnt;
    w_pix_addr = r_pix_addr;
    w_np       = r_np;
    w_nw       = r_nw;
    w_write_en = 1'b0;
    w_addr     = r_addr;
    w_data     = r_data;
    w_busy     = r_busy;
    w_done     = r_done;
    w_err      = r_err;
`ifdef LOADER_CHECKSUM_EN
    w_checksum = r_checksum;
`endif

    case (r_state)
      IDLE, DONE: begin
        if (go) begin
          w_state   = HDR;
          w_hdr_cnt = CW'(ADDR_WHITE);
          w_busy    = 1'b1;
          w_done    = 1'b0;
          w_err     = 1'b0;
`ifdef LOADER_CHECKSUM_EN
          w_checksum = '0;
`endif
        end
      end

      HDR: begin
        if (w_accept) begin
          w_write_en = 1'b1;
          w_addr     = AW'(r_hdr_cnt);
          w_data     = s_data;
`ifdef LOADER_CHECKSUM_EN
          w_checksum = r_checksum + s_data;
`endif
          if (r_hdr_cnt == CW'(ADDR_PSIZE)) w_np = s_data;
          if (r_hdr_cnt == CW'(ADDR_WSIZE)) w_nw = s_data;
          if (r_hdr_cnt == CW'(ADDR_HDR_LAST)) begin
            w_state = CALC;
          end else begin
            w_hdr_cnt = r_hdr_cnt + CW'(1);
          end
        end
      end

      CALC: begin
        if (w_range_err) begin
          w_state = DONE;
          w_err   = 1'b1;
          w_busy  = 1'b0;
          w_done  = 1'b1;
        end else if (w_total == '0) begin
          w_state = START;
        end else begin
          w_state    = PIX;
          w_pix_addr = AW'(ADDR_PIX0);
        end
      end

      PIX: begin
        if (w_accept) begin
          w_write_en = 1'b1;
          w_addr     = r_pix_addr;
          w_data     = s_data;
`ifdef LOADER_CHECKSUM_EN
          w_checksum = r_checksum + s_data;
`endif
          w_pix_addr = r_pix_addr + AW'(1);
          if (r_pix_addr == AW'(ADDR_HDR_LAST) + w_total) w_state = START;
        end
      end

      START: begin
        w_write_en = 1'b1;
        w_addr     = AW'(ADDR_CTRL);
        w_data     = Amba_Word'(1);
        w_state    = DONE;
        w_busy     = 1'b0;
        w_done     = 1'b1;
      end

      default: w_state = IDLE;
    endcase

    w_s_ready = (w_state == HDR) || (w_state == PIX);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_hdr_cnt  <= '0;
      r_pix_addr <= '0;
      r_np       <= '0;
      r_nw       <= '0;
      r_s_ready  <= 1'b0;
      r_write_en <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_checksum <= '0;
`endif
    end else begin
      r_state    <= w_state;
      r_hdr_cnt  <= w_hdr_cnt;
      r_pix_addr <= w_pix_addr;
      r_np       <= w_np;
      r_nw       <= w_nw;
      r_s_ready  <= w_s_ready;
      r_write_en <= w_write_en;
      r_addr     <= w_addr;
      r_data     <= w_data;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_err      <= w_err;
`ifdef LOADER_CHECKSUM_EN
      r_checksum <= w_checksum;
`endif
    end
  end

  assign s_ready  = r_s_ready;
  assign write_en = r_write_en;
  assign addr     = r_addr;
  assign data_out = r_data;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;
`ifdef LOADER_CHECKSUM_EN
  assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_bank_loader.sv
// Self-checking bench for bank_loader. A reference model derives the
// expected bank write sequence from the header rules; a negedge monitor logs
// every bank write and checks each one follows an accepted word or is CTRL.
module tb_bank_loader;

  localparam int W  = 16;
  localparam int AW = 21;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          go = 1'b0;
  logic          s_valid = 1'b0;
  logic [W-1:0]  s_data = '0;
  logic          s_ready, write_en, busy, done, err;
  logic [AW-1:0] addr;
  logic [W-1:0]  data_out;
`ifdef LOADER_CHECKSUM_EN
  logic [W-1:0]  checksum;
`endif

  bank_loader dut (
    .clk      (clk),
    .rst      (rst),
    .go       (go),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .write_en (write_en),
    .addr     (addr),
    .data_out (data_out),
    .busy     (busy),
    .done     (done),
    .err      (err)
`ifdef LOADER_CHECKSUM_EN
    ,
    .checksum (checksum)
`endif
  );

  always #5 clk = ~clk;

  int total_cnt = 0;
  int bad_cnt   = 0;

  // Observed and expected bank write sequences
  int         log_a[$];
  logic [W-1:0] log_d[$];
  int         exp_a[$];
  logic [W-1:0] exp_d[$];
  bit         exp_err;
  logic [W-1:0] exp_sum;

  // Stream contents for the current load
  logic [W-1:0] hdr_q[$];
  logic [W-1:0] pix_q[$];

  bit           pend = 1'b0;
  logic [W-1:0] pend_data = '0;
  int           viol = 0;
  int           accepted = 0;

  // Log bank writes; each write must carry the previous cycle's accepted word,
  // or be the CTRL launch write when nothing was accepted.
  always @(negedge clk) begin
    if (write_en === 1'b1) begin
      log_a.push_back(int'(addr));
      log_d.push_back(data_out);
      if (pend) begin
        if (data_out !== pend_data) viol++;
      end else if (!(addr == '0 && data_out == W'(1))) begin
        viol++;
      end
    end else if (pend) begin
      viol++;
    end
    pend      = rst && s_valid && (s_ready === 1'b1);
    pend_data = s_data;
  end

  // Expected writes: header at 1..9; if sizes legal, Np^2+Nw^2 pixels from
  // 0x0A then CTRL=1 at address 0.
  function automatic void model();
    exp_a.delete();
    exp_d.delete();
    exp_sum = '0;
    exp_err = (int'(hdr_q[1]) > 720) || (int'(hdr_q[2]) > 720);
    for (int i = 0; i < 9; i++) begin
      exp_a.push_back(i + 1);
      exp_d.push_back(hdr_q[i]);
      exp_sum = exp_sum + hdr_q[i];
    end
    if (!exp_err) begin
      for (int k = 0; k < pix_q.size(); k++) begin
        exp_a.push_back(10 + k);
        exp_d.push_back(pix_q[k]);
        exp_sum = exp_sum + pix_q[k];
      end
      exp_a.push_back(0);
      exp_d.push_back(W'(1));
    end
  endfunction

  function automatic int npix_of(input logic [W-1:0] np, input logic [W-1:0] nw);
    return int'(np) * int'(np) + int'(nw) * int'(nw);
  endfunction

  function automatic int log_mismatch();
    int n;
    n = (log_a.size() < exp_a.size()) ? log_a.size() : exp_a.size();
    for (int i = 0; i < n; i++)
      if (log_a[i] != exp_a[i] || log_d[i] !== exp_d[i]) return i;
    if (log_a.size() != exp_a.size()) return n;
    return -1;
  endfunction

  function automatic void set_header(input int np, input int nw);
    hdr_q.delete();
    pix_q.delete();
    hdr_q.push_back(W'($urandom));
    hdr_q.push_back(W'(np));
    hdr_q.push_back(W'(nw));
    for (int i = 0; i < 6; i++) hdr_q.push_back(W'($urandom));
  endfunction

  // All tasks start and end at posedge+#1.
  task automatic start_load();
    log_a.delete();
    log_d.delete();
    accepted = 0;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  // mode 0: continuous, 1: valid every other cycle, 2: random valid.
  task automatic send_words(input int mode, input bit go_noise, output bit to);
    int  i;
    int  cyc;
    int  n;
    bit  acc;
    logic [W-1:0] w;
    i   = 0;
    cyc = 0;
    to  = 1'b0;
    n   = hdr_q.size() + pix_q.size();
    while (i < n) begin
      if (cyc > 4000) begin
        to = 1'b1;
        break;
      end
      w = (i < hdr_q.size()) ? hdr_q[i] : pix_q[i - hdr_q.size()];
      case (mode)
        0:       s_valid = 1'b1;
        1:       s_valid = (cyc % 2 == 1);
        default: s_valid = ($urandom_range(0, 2) != 0);
      endcase
      s_data = w;
      if (go_noise) go = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = s_valid && (s_ready === 1'b1);
      @(posedge clk); #1;
      if (acc) begin
        i++;
        accepted++;
      end
      cyc++;
    end
    s_valid = 1'b0;
    go      = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit to);
    to = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        to = 1'b0;
        break;
      end
    end
    repeat (2) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (write_en !== 1'b0) begin bad_cnt++; $display("FAIL reset_write_en: got %b want 0", write_en); end
    total_cnt++; if (addr !== '0) begin bad_cnt++; $display("FAIL reset_addr: got %0h want 0", addr); end
    total_cnt++; if (data_out !== '0) begin bad_cnt++; $display("FAIL reset_data: got %0h want 0", data_out); end
    total_cnt++; if (s_ready !== 1'b0) begin bad_cnt++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
    total_cnt++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      bad_cnt++; $display("FAIL reset_flags: got busy=%b done=%b err=%b want 000", busy, done, err);
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic(input int mode, input string tag);
    int hv[9] = '{255, 4, 2, 4, 10, 5, 50, 90, 10};
    bit to1, to2;
    int idx;
    int v0;
    hdr_q.delete();
    pix_q.delete();
    for (int i = 0; i < 9; i++) hdr_q.push_back(W'(hv[i]));
    for (int k = 0; k < 20; k++) pix_q.push_back(W'(k));
    model();
    v0 = viol;
    start_load();
    total_cnt++; if (busy !== 1'b1 || done !== 1'b0) begin
      bad_cnt++; $display("FAIL %s_go: got busy=%b done=%b want busy=1 done=0", tag, busy, done);
    end
    send_words(mode, 1'b0, to1);
    wait_done(200, to2);
    total_cnt++; if (to1 || to2) begin bad_cnt++; $display("FAIL %s_timeout: got timeout want completion", tag); end
    idx = log_mismatch();
    total_cnt++; if (idx != -1) begin
      bad_cnt++; $display("FAIL %s_writes: got %0d writes want %0d, first difference at %0d", tag, log_a.size(), exp_a.size(), idx);
    end
    total_cnt++; if (log_a.size() < 30 || log_a[9] != 'h0A || log_d[9] !== W'(0) || log_a[28] != 'h1D || log_d[28] !== W'(19)) begin
      bad_cnt++; $display("FAIL %s_pixel_ends: got %0d writes want pixel0@0x0A and pixel19@0x1D", tag, log_a.size());
    end
    total_cnt++; if (log_a.size() < 30 || log_a[29] != 0 || log_d[29] !== W'(1)) begin
      bad_cnt++; $display("FAIL %s_ctrl: got %0d writes want last write addr 0 data 1", tag, log_a.size());
    end
    total_cnt++; if (accepted != 29) begin bad_cnt++; $display("FAIL %s_accepted: got %0d want 29", tag, accepted); end
    total_cnt++; if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0) begin
      bad_cnt++; $display("FAIL %s_final_flags: got done=%b busy=%b err=%b want 1 0 0", tag, done, busy, err);
    end
    total_cnt++; if (viol != v0) begin bad_cnt++; $display("FAIL %s_write_timing: got %0d stray writes want 0", tag, viol - v0); end
`ifdef LOADER_CHECKSUM_EN
    total_cnt++; if (checksum !== exp_sum) begin bad_cnt++; $display("FAIL %s_checksum: got %0d want %0d", tag, checksum, exp_sum); end
`endif
  endtask

  task automatic test_zero_size();
    bit to1, to2;
    int idx;
    set_header(0, 0);
    model();
    start_load();
    send_words(0, 1'b0, to1);
    wait_done(100, to2);
    total_cnt++; if (to1 || to2) begin bad_cnt++; $display("FAIL zero_timeout: got timeout want completion"); end
    idx = log_mismatch();
    total_cnt++; if (idx != -1 || log_a.size() != 10) begin
      bad_cnt++; $display("FAIL zero_writes: got %0d writes want 10, first difference at %0d", log_a.size(), idx);
    end
    total_cnt++; if (done !== 1'b1 || err !== 1'b0) begin bad_cnt++; $display("FAIL zero_flags: got done=%b err=%b want 1 0", done, err); end
  endtask

  task automatic test_size_error();
    bit to1, to2;
    int idx;
    set_header(721, 1);
    model();
    start_load();
    send_words(0, 1'b0, to1);
    wait_done(100, to2);
    total_cnt++; if (to1 || to2) begin bad_cnt++; $display("FAIL err_timeout: got timeout want completion"); end
    total_cnt++; if (err !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
      bad_cnt++; $display("FAIL err_flags: got err=%b done=%b busy=%b want 1 1 0", err, done, busy);
    end
    idx = log_mismatch();
    total_cnt++; if (idx != -1) begin bad_cnt++; $display("FAIL err_writes: got %0d writes want %0d (no CTRL)", log_a.size(), exp_a.size()); end
`ifdef LOADER_CHECKSUM_EN
    total_cnt++; if (checksum !== exp_sum) begin bad_cnt++; $display("FAIL err_checksum: got %0d want %0d", checksum, exp_sum); end
`endif
    // Recovery load clears err and loads 2*2+1*1 = 5 pixels
    set_header(2, 1);
    for (int k = 0; k < 5; k++) pix_q.push_back(W'($urandom));
    model();
    start_load();
    total_cnt++; if (err !== 1'b0) begin bad_cnt++; $display("FAIL err_clear_on_go: got %b want 0", err); end
    send_words(0, 1'b0, to1);
    wait_done(100, to2);
    idx = log_mismatch();
    total_cnt++; if (to1 || to2 || idx != -1 || log_a.size() != 15) begin
      bad_cnt++; $display("FAIL err_recovery_writes: got %0d writes want 15, diff at %0d", log_a.size(), idx);
    end
    total_cnt++; if (err !== 1'b0 || done !== 1'b1) begin bad_cnt++; $display("FAIL err_recovery_flags: got err=%b done=%b want 0 1", err, done); end
  endtask

  task automatic test_abort();
    bit to1;
    bit has_ctrl;
    set_header(2, 2);
    for (int k = 0; k < 3; k++) pix_q.push_back(W'($urandom));
    start_load();
    send_words(0, 1'b0, to1);
    rst = 1'b0;
    @(posedge clk); #1;
    total_cnt++; if (write_en !== 1'b0 || s_ready !== 1'b0 || busy !== 1'b0) begin
      bad_cnt++; $display("FAIL abort_outputs: got write_en=%b s_ready=%b busy=%b want 000", write_en, s_ready, busy);
    end
    rst = 1'b1;
    s_valid = 1'b1;
    s_data  = W'($urandom);
    repeat (6) @(posedge clk);
    #1;
    s_valid = 1'b0;
    has_ctrl = 1'b0;
    foreach (log_a[i]) if (log_a[i] == 0) has_ctrl = 1'b1;
    total_cnt++; if (to1 || log_a.size() != 12 || has_ctrl) begin
      bad_cnt++; $display("FAIL abort_writes: got %0d writes ctrl=%b want 12 writes no ctrl", log_a.size(), has_ctrl);
    end
    total_cnt++; if (done !== 1'b0 || busy !== 1'b0) begin bad_cnt++; $display("FAIL abort_idle: got done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_random();
    bit to1, to2;
    int idx;
    int np, nw;
    int v0;
    for (int it = 0; it < 8; it++) begin
      np = (it == 3) ? $urandom_range(721, 1000) : $urandom_range(0, 4);
      nw = $urandom_range(0, 4);
      set_header(np, nw);
      if (np <= 720)
        for (int k = 0; k < npix_of(W'(np), W'(nw)); k++) pix_q.push_back(W'($urandom));
      model();
      v0 = viol;
      start_load();
      send_words(2, 1'b1, to1);
      wait_done(300, to2);
      idx = log_mismatch();
      total_cnt++; if (to1 || to2 || idx != -1) begin
        bad_cnt++; $display("FAIL rand%0d_writes: got %0d writes timeout=%b want %0d, diff at %0d", it, log_a.size(), to1 | to2, exp_a.size(), idx);
      end
      total_cnt++; if (err !== exp_err || done !== 1'b1) begin
        bad_cnt++; $display("FAIL rand%0d_flags: got err=%b done=%b want err=%b done=1", it, err, done, exp_err);
      end
      total_cnt++; if (viol != v0) begin bad_cnt++; $display("FAIL rand%0d_write_timing: got %0d stray writes want 0", it, viol - v0); end
`ifdef LOADER_CHECKSUM_EN
      total_cnt++; if (checksum !== exp_sum) begin bad_cnt++; $display("FAIL rand%0d_checksum: got %0d want %0d", it, checksum, exp_sum); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic(0, "basic");
    test_basic(1, "stall");
    test_zero_size();
    test_size_error();
    test_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
